// File: rtl/load_store_byte_sequencer.sv
// Load/store initiator that splits byte/halfword/word requests into single-byte memory accesses.
// Optional macro ALIGN_CHECK_EN rejects misaligned halfword/word requests instead of splitting them.
module load_store_byte_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic              req_write_in,
    input  logic [1:0]        req_size_in,
    input  logic              req_signed_in,
    input  logic [ADDR_W-1:0] req_addr_in,
    input  logic [DATA_W-1:0] req_wdata_in,
    output logic              resp_valid_out,
    output logic [DATA_W-1:0] resp_rdata_out,
    output logic              resp_err_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              mem_we_out,
    output logic [7:0]        mem_wd_out,
    input  logic [7:0]        mem_rd_in
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              r_state;
    logic                r_write;
    logic                r_signed;
    logic [1:0]          r_size;
    logic [1:0]          r_cnt;
    logic [1:0]          r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_buf;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_misaligned;
    logic                w_reject;
    logic [4:0]          w_bit_idx;
    logic [DATA_W-1:0]   w_buf_next;
    logic [DATA_W-1:0]   w_ext;

`ifdef ALIGN_CHECK_EN
    assign w_misaligned = ((req_size_in == 2'b01) && req_addr_in[0]) ||
                          ((req_size_in == 2'b10) && (req_addr_in[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_reject  = (req_size_in == 2'b11) || w_misaligned;
    assign w_bit_idx = {r_cnt, 3'b000};

    // Final byte of a load lands in the buffer on the same edge the response is formed.
    always_comb begin
        w_buf_next = r_buf;
        w_buf_next[w_bit_idx +: 8] = mem_rd_in;
    end

    always_comb begin
        w_ext = w_buf_next;
        case (r_size)
            2'b00:   w_ext = {{24{r_signed & w_buf_next[7]}}, w_buf_next[7:0]};
            2'b01:   w_ext = {{16{r_signed & w_buf_next[15]}}, w_buf_next[15:0]};
            default: w_ext = w_buf_next;
        endcase
    end

    assign req_ready_out  = (r_state == IDLE) && !reset_in;
    assign resp_valid_out = (r_state == RESP) && !reset_in;
    assign resp_rdata_out = r_rdata;
    assign resp_err_out   = r_err;
    assign mem_addr_out   = (r_state == ACCESS) ? r_addr + ADDR_W'(r_cnt) : '0;
    assign mem_we_out     = (r_state == ACCESS) && r_write && !reset_in;
    assign mem_wd_out     = ((r_state == ACCESS) && r_write) ? r_wdata[w_bit_idx +: 8] : '0;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state  <= IDLE;
            r_write  <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= 2'b00;
            r_cnt    <= 2'b00;
            r_last   <= 2'b00;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_buf    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_in) begin
                        r_write  <= req_write_in;
                        r_size   <= req_size_in;
                        r_signed <= req_signed_in;
                        r_addr   <= req_addr_in;
                        r_wdata  <= req_wdata_in;
                        r_cnt    <= 2'b00;
                        r_buf    <= '0;
                        case (req_size_in)
                            2'b00:   r_last <= 2'd0;
                            2'b01:   r_last <= 2'd1;
                            default: r_last <= 2'd3;
                        endcase
                        if (w_reject) begin
                            r_state <= RESP;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                        end else begin
                            r_state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!r_write) r_buf <= w_buf_next;
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == r_last) begin
                        r_state <= RESP;
                        r_err   <= 1'b0;
                        r_rdata <= r_write ? '0 : w_ext;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_byte_sequencer.sv
// Directed self-checking bench for load_store_byte_sequencer with a 256-byte memory model.
// Expectations for misaligned requests follow ALIGN_CHECK_EN when it is defined.
module tb_load_store_byte_sequencer;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        req_write_in;
    logic [1:0]  req_size_in;
    logic        req_signed_in;
    logic [31:0] req_addr_in;
    logic [31:0] req_wdata_in;
    logic        resp_valid_out;
    logic [31:0] resp_rdata_out;
    logic        resp_err_out;
    logic [31:0] mem_addr_out;
    logic        mem_we_out;
    logic [7:0]  mem_wd_out;
    logic [7:0]  mem_rd_in;

    logic [7:0]  mem [0:255];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cycle    = 0;
    int          resp_cnt = 0;
    int          acc_cnt  = 0;
    int          acc_cyc [$];

    load_store_byte_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_write_in   (req_write_in),
        .req_size_in    (req_size_in),
        .req_signed_in  (req_signed_in),
        .req_addr_in    (req_addr_in),
        .req_wdata_in   (req_wdata_in),
        .resp_valid_out (resp_valid_out),
        .resp_rdata_out (resp_rdata_out),
        .resp_err_out   (resp_err_out),
        .mem_addr_out   (mem_addr_out),
        .mem_we_out     (mem_we_out),
        .mem_wd_out     (mem_wd_out),
        .mem_rd_in      (mem_rd_in)
    );

    always #5 clk_in = ~clk_in;

    assign mem_rd_in = mem[mem_addr_out[7:0]];

    always @(posedge clk_in) begin
        cycle <= cycle + 1;
        if (mem_we_out) mem[mem_addr_out[7:0]] <= mem_wd_out;
        if (resp_valid_out) resp_cnt <= resp_cnt + 1;
        if (req_valid_in && req_ready_out) begin
            acc_cnt <= acc_cnt + 1;
            acc_cyc.push_back(cycle);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Caller is at a negedge with the DUT idle; returns at a negedge in the next idle cycle.
    task automatic issue(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd, input int n,
                         input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] wd_v;
        wd_v = wd;
        req_write_in  = w;
        req_size_in   = sz;
        req_signed_in = sg;
        req_addr_in   = addr;
        req_wdata_in  = wd;
        req_valid_in  = 1'b1;
        check({tag, " ready"}, {31'd0, req_ready_out}, 32'd1);
        @(posedge clk_in);
        #1 req_valid_in = 1'b0;
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge clk_in);
            check($sformatf("%s addr%0d", tag, k), mem_addr_out, addr + k);
            check($sformatf("%s we%0d", tag, k), {31'd0, mem_we_out}, {31'd0, w});
            if (w) check($sformatf("%s wd%0d", tag, k), {24'd0, mem_wd_out}, {24'd0, wd_v[8*k +: 8]});
            check($sformatf("%s nrsp%0d", tag, k), {31'd0, resp_valid_out}, 32'd0);
        end
        @(negedge clk_in);
        check({tag, " rvalid"}, {31'd0, resp_valid_out}, 32'd1);
        check({tag, " rdata"}, resp_rdata_out, exp_rd);
        check({tag, " err"}, {31'd0, resp_err_out}, {31'd0, exp_err});
        check({tag, " we_resp"}, {31'd0, mem_we_out}, 32'd0);
        @(negedge clk_in);
        check({tag, " ready_after"}, {31'd0, req_ready_out}, 32'd1);
        check({tag, " rvalid_drop"}, {31'd0, resp_valid_out}, 32'd0);
        check({tag, " rdata_hold"}, resp_rdata_out, exp_rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        int ac0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset_in      = 1'b1;
        req_valid_in  = 1'b0;
        req_write_in  = 1'b0;
        req_size_in   = 2'b00;
        req_signed_in = 1'b0;
        req_addr_in   = '0;
        req_wdata_in  = '0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("rst ready", {31'd0, req_ready_out}, 32'd0);
        check("rst rvalid", {31'd0, resp_valid_out}, 32'd0);
        check("rst we", {31'd0, mem_we_out}, 32'd0);
        reset_in = 1'b0;
        @(negedge clk_in);
        check("idle ready", {31'd0, req_ready_out}, 32'd1);
        check("idle rdata", resp_rdata_out, 32'd0);
        check("idle err", {31'd0, resp_err_out}, 32'd0);
        check("idle addr", mem_addr_out, 32'd0);

        issue("st_w", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 4, 32'd0, 1'b0);
        check("mem10", {24'd0, mem[8'h10]}, 32'hEF);
        check("mem13", {24'd0, mem[8'h13]}, 32'hDE);
        issue("ld_w", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 4, 32'hDEADBEEF, 1'b0);

        mem[8'h20] = 8'h80;
        mem[8'h21] = 8'h55;
        mem[8'h22] = 8'h34;
        mem[8'h23] = 8'h92;
        issue("ld_bs", 1'b0, 2'b00, 1'b1, 32'h20, 32'd0, 1, 32'hFFFFFF80, 1'b0);
        issue("ld_bu", 1'b0, 2'b00, 1'b0, 32'h20, 32'd0, 1, 32'h00000080, 1'b0);
        issue("ld_hs", 1'b0, 2'b01, 1'b1, 32'h22, 32'd0, 2, 32'hFFFF9234, 1'b0);
        issue("ld_hu", 1'b0, 2'b01, 1'b0, 32'h22, 32'd0, 2, 32'h00009234, 1'b0);
        issue("ld_bs_pos", 1'b0, 2'b00, 1'b1, 32'h21, 32'd0, 1, 32'h00000055, 1'b0);

        issue("ill", 1'b1, 2'b11, 1'b0, 32'h30, 32'hFFFFFFFF, 0, 32'd0, 1'b1);
        check("ill mem30", {24'd0, mem[8'h30]}, 32'd0);

`ifdef ALIGN_CHECK_EN
        issue("ld_h_mis", 1'b0, 2'b01, 1'b0, 32'h21, 32'd0, 0, 32'd0, 1'b1);
        issue("st_w_wrap", 1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'hA1B2C3D4, 0, 32'd0, 1'b1);
        check("wrap memFE", {24'd0, mem[8'hFE]}, 32'd0);
`else
        issue("ld_h_mis", 1'b0, 2'b01, 1'b0, 32'h21, 32'd0, 2, 32'h00003455, 1'b0);
        issue("st_w_wrap", 1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'hA1B2C3D4, 4, 32'd0, 1'b0);
        check("wrap memFE", {24'd0, mem[8'hFE]}, 32'hD4);
        check("wrap mem01", {24'd0, mem[8'h01]}, 32'hA1);
`endif
        issue("ld_err_clr", 1'b0, 2'b00, 1'b0, 32'h20, 32'd0, 1, 32'h00000080, 1'b0);

        // Reset asserted for exactly cycle T+3 of a word store.
        rc0 = resp_cnt;
        req_write_in  = 1'b1;
        req_size_in   = 2'b10;
        req_signed_in = 1'b0;
        req_addr_in   = 32'h40;
        req_wdata_in  = 32'h11223344;
        req_valid_in  = 1'b1;
        @(posedge clk_in);
        #1 req_valid_in = 1'b0;
        @(negedge clk_in);
        check("rst_mid a0", mem_addr_out, 32'h40);
        @(negedge clk_in);
        check("rst_mid a1", mem_addr_out, 32'h41);
        @(posedge clk_in);
        #1 reset_in = 1'b1;
        @(negedge clk_in);
        check("rst_mid we_gated", {31'd0, mem_we_out}, 32'd0);
        check("rst_mid ready", {31'd0, req_ready_out}, 32'd0);
        @(posedge clk_in);
        #1 reset_in = 1'b0;
        @(negedge clk_in);
        check("rst_mid ready_after", {31'd0, req_ready_out}, 32'd1);
        check("rst_mid m40", {24'd0, mem[8'h40]}, 32'h44);
        check("rst_mid m41", {24'd0, mem[8'h41]}, 32'h33);
        check("rst_mid m42", {24'd0, mem[8'h42]}, 32'h00);
        check("rst_mid m43", {24'd0, mem[8'h43]}, 32'h00);
        repeat (3) @(negedge clk_in);
        check("rst_mid no_resp", resp_cnt, rc0);

        // Held-high valid with halfword loads: accepts every N+2 = 4 cycles.
        rc0 = resp_cnt;
        ac0 = acc_cnt;
        acc_cyc.delete();
        req_write_in  = 1'b0;
        req_size_in   = 2'b01;
        req_signed_in = 1'b1;
        req_addr_in   = 32'h22;
        req_valid_in  = 1'b1;
        repeat (10) @(posedge clk_in);
        #1 req_valid_in = 1'b0;
        repeat (6) @(negedge clk_in);
        check("hold accepts", acc_cnt - ac0, 32'd3);
        check("hold resps", resp_cnt - rc0, 32'd3);
        if (acc_cyc.size() == 3) begin
            check("hold gap1", acc_cyc[1] - acc_cyc[0], 32'd4);
            check("hold gap2", acc_cyc[2] - acc_cyc[1], 32'd4);
        end else begin
            check("hold log", acc_cyc.size(), 32'd3);
        end
        check("hold rdata", resp_rdata_out, 32'hFFFF9234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
